// File: rtl/prefetch_queue_pkg.sv
// Shared constants and helpers for the instruction prefetch queue.
// Widths are derived from the top-level parameters through these helpers.
package prefetch_queue_pkg;

  localparam int unsigned DEF_XLEN  = 16;
  localparam int unsigned DEF_DEPTH = 4;

  // Pointer width for a power-of-two queue; never less than one bit.
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prefetch_queue_fetch_fifo.sv
// Synchronous power-of-two FIFO holding fetched {instr, pc} entries.
// A clear takes priority over push and pop in the same cycle.
module fetch_fifo
  import prefetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PW = ptr_bits(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // NOTE: storage is reset so the head reads as zero out of reset; at this
  // depth that costs little, and it keeps out_instr/out_pc free of X.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) storage[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= din;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = storage[rd_ptr];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction-fetch front end: issues reads to one-cycle-latency memory,
// queues {instr, pc} pairs and hands them to decode over valid/ready.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = DEF_XLEN,
  parameter int unsigned     DEPTH    = DEF_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int unsigned    LW       = ptr_bits(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_ren,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready,
  output logic [LW-1:0]   level
);

  logic [XLEN-1:0]   fetch_pc;
  logic              inflight;
  logic [XLEN-1:0]   inflight_pc;
  logic [LW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic              pop;
  logic              push;
  logic              issue;
  logic [LW:0]       credit_used;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~redirect;
  assign push      = inflight & ~redirect;

  // Credit counts queued entries plus the outstanding read, less this
  // cycle's pop, so a response always finds a free slot when it lands.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    credit_used = {1'b0, count} + (LW+1)'(inflight) - (LW+1)'(pop);
    issue       = 1'b0;
    if (rst_n && !halt && !redirect && (credit_used < (LW+1)'(DEPTH)))
      issue = 1'b1;
  end

  assign mem_ren  = issue;
  assign mem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 1'b1;
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({mem_data, inflight_pc}),
    .dout  (head),
    .count (count)
  );

  assign out_instr = head[2*XLEN-1:XLEN];
  assign out_pc    = head[XLEN-1:0];
  assign level     = count;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: startup, backpressure, streaming,
// redirect flush, halt with PC wrap and asynchronous reset mid-stream.
module tb_prefetch_queue;

  localparam int unsigned     XLEN     = 16;
  localparam int unsigned     DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = 16'h0010;
  localparam logic [XLEN-1:0] PATTERN  = 16'hA5A5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mem_ren;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;
  logic [2:0]      level;

  int errors = 0;
  int checks = 0;

  prefetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_ren     (mem_ren),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .level       (level)
  );

  always #5 clk = ~clk;

  // Synchronous memory, one-cycle read latency, contents = addr ^ 0xA5A5.
  always @(posedge clk) begin
    if (mem_ren) mem_data <= mem_addr ^ PATTERN;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [XLEN-1:0] exp_pc;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    out_ready   = 1'b0;
    mem_data    = '0;

    // Reset held for three cycles.
    repeat (3) step();
    check("rst_mem_ren",   32'(mem_ren),   32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'(RESET_PC));
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    check("rst_out_pc",    32'(out_pc),    32'd0);
    check("rst_level",     32'(level),     32'd0);

    // Startup: cycle 1 issues RESET_PC, cycle 3 presents it.
    rst_n = 1'b1;
    #1;
    check("c1_mem_ren",  32'(mem_ren),  32'd1);
    check("c1_mem_addr", 32'(mem_addr), 32'h0010);
    step();
    check("c2_out_valid", 32'(out_valid), 32'd0);
    check("c2_mem_addr",  32'(mem_addr),  32'h0011);
    step();
    check("c3_out_valid", 32'(out_valid), 32'd1);
    check("c3_out_pc",    32'(out_pc),    32'h0010);
    check("c3_out_instr", 32'(out_instr), 32'hA5B5);
    check("c3_level",     32'(level),     32'd1);

    // Backpressure: 0x10..0x13 issued, queue fills to DEPTH.
    step();
    check("c4_mem_addr", 32'(mem_addr), 32'h0013);
    check("c4_mem_ren",  32'(mem_ren),  32'd1);
    step();
    check("c5_level",   32'(level),   32'd3);
    check("c5_mem_ren", 32'(mem_ren), 32'd0);
    step();
    check("full_level",   32'(level),   32'd4);
    check("full_mem_ren", 32'(mem_ren), 32'd0);
    check("stall_out_pc", 32'(out_pc),  32'h0010);
    repeat (2) step();
    check("full_hold_level",   32'(level),     32'd4);
    check("full_hold_mem_ren", 32'(mem_ren),   32'd0);
    check("stall_hold_pc",     32'(out_pc),    32'h0010);
    check("stall_hold_instr",  32'(out_instr), 32'hA5B5);

    // One pop lets exactly one new read out.
    out_ready = 1'b1;
    #1;
    check("pop1_mem_ren",  32'(mem_ren),  32'd1);
    check("pop1_mem_addr", 32'(mem_addr), 32'h0014);
    step();
    out_ready = 1'b0;
    #1;
    check("pop1_level_a", 32'(level),   32'd3);
    check("pop1_ren_a",   32'(mem_ren), 32'd0);
    check("pop1_head",    32'(out_pc),  32'h0011);
    step();
    check("pop1_level_b", 32'(level),   32'd4);
    check("pop1_ren_b",   32'(mem_ren), 32'd0);

    // Streaming: one instruction per cycle with out_ready high.
    out_ready = 1'b1;
    exp_pc    = 16'h0011;
    #1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stream_pc_%0d", i),    32'(out_pc),    32'(exp_pc));
      check($sformatf("stream_instr_%0d", i), 32'(out_instr), 32'(exp_pc ^ PATTERN));
      exp_pc = exp_pc + 1'b1;
      step();
    end

    // Redirect with three queued and one read in flight.
    check("pre_redir_level", 32'(level),   32'd3);
    check("pre_redir_ren",   32'(mem_ren), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    #1;
    check("redir_no_issue", 32'(mem_ren), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check("r1_level",     32'(level),     32'd0);
    check("r1_out_valid", 32'(out_valid), 32'd0);
    check("r1_mem_ren",   32'(mem_ren),   32'd1);
    check("r1_mem_addr",  32'(mem_addr),  32'h0200);
    step();
    check("r2_level",     32'(level),     32'd0);
    check("r2_out_valid", 32'(out_valid), 32'd0);
    step();
    check("r3_out_valid", 32'(out_valid), 32'd1);
    check("r3_out_pc",    32'(out_pc),    32'h0200);
    check("r3_out_instr", 32'(out_instr), 32'hA7A5);

    // Halt and wrap: restart at 0xFFFE, halt once 0xFFFF has issued.
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    #1;
    check("w1_mem_addr", 32'(mem_addr), 32'hFFFE);
    step();
    check("w2_mem_addr", 32'(mem_addr), 32'hFFFF);
    check("w2_mem_ren",  32'(mem_ren),  32'd1);
    step();
    halt = 1'b1;
    #1;
    check("h1_mem_ren",   32'(mem_ren),   32'd0);
    check("h1_out_valid", 32'(out_valid), 32'd1);
    check("h1_out_pc",    32'(out_pc),    32'hFFFE);
    step();
    check("h2_mem_ren", 32'(mem_ren), 32'd0);
    check("h2_out_pc",  32'(out_pc),  32'hFFFF);
    step();
    check("h3_mem_ren",   32'(mem_ren),   32'd0);
    check("h3_out_valid", 32'(out_valid), 32'd0);
    check("h3_level",     32'(level),     32'd0);
    step();
    check("h4_mem_ren", 32'(mem_ren), 32'd0);
    halt = 1'b0;
    #1;
    check("wrap_mem_ren",  32'(mem_ren),  32'd1);
    check("wrap_mem_addr", 32'(mem_addr), 32'h0000);
    repeat (2) step();
    check("wrap_out_valid", 32'(out_valid), 32'd1);
    check("wrap_out_pc",    32'(out_pc),    32'h0000);
    check("wrap_out_instr", 32'(out_instr), 32'hA5A5);

    // Asynchronous reset pulse between edges, with a read outstanding.
    step();
    check("pre_arst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_level",     32'(level),     32'd0);
    check("arst_mem_ren",   32'(mem_ren),   32'd0);
    check("arst_mem_addr",  32'(mem_addr),  32'(RESET_PC));
    check("arst_out_pc",    32'(out_pc),    32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("rs1_mem_ren",  32'(mem_ren),  32'd1);
    check("rs1_mem_addr", 32'(mem_addr), 32'(RESET_PC));
    step();
    check("rs2_out_valid", 32'(out_valid), 32'd0);
    check("rs2_level",     32'(level),     32'd0);
    step();
    check("rs3_out_valid", 32'(out_valid), 32'd1);
    check("rs3_out_pc",    32'(out_pc),    32'h0010);
    check("rs3_out_instr", 32'(out_instr), 32'hA5B5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Parametrised instruction-fetch front end that replaces the fixed two-stage fetch pair of the pipelined CPU. It drives the instruction read port of synchronous memory with one-cycle read latency, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to decode with a valid/ready handshake. It supports branch/halt redirects and a fetch halt, and sustains one instruction per cycle under no backpressure.

## Interface
- XLEN, 16: instruction, address and PC width.
- DEPTH, 4: queue entries; a power of two, at least 2.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_ren  out  1  instruction read enable.
- mem_addr  out  XLEN  instruction address; the value is valid when mem_ren is 1.
- mem_data  in  XLEN  read data for the address issued in the previous cycle.
- redirect  in  1  flush everything and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch PC.
- halt  in  1  level signal; while high, no new reads are issued.
- out_valid  out  1  the queue head is valid.
- out_instr  out  XLEN  head instruction.
- out_pc  out  XLEN  head PC.
- out_ready  in  1  decode accepts the head; this is the inverse of stall.
- level  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- Registers:
  - fetch PC.
  - in-flight flag and in-flight PC for the one outstanding read.
  - queue: storage, read and write pointers, count.
- Pop: when out_valid && out_ready && !redirect.
- Issue condition: !halt && !redirect && (count + inflight − pop) < DEPTH.
- On issue:
  - mem_ren = 1 and mem_addr = fetch PC.
  - fetch PC increments by 1 (word addressed), modulo 2^XLEN, so 0xFFFF wraps to 0x0000.
  - The in-flight flag is set and the in-flight PC captures the issued PC.
- Response: the cycle after an issue, if the in-flight flag is set, {mem_data, in-flight PC} is pushed into the queue. The credit rule guarantees the queue is never full at push time.
- Redirect (takes priority over everything):
  - Queue is cleared.
  - In-flight flag is cleared, so the response arriving next cycle is dropped.
  - Any pop in the same cycle is ignored.
  - Fetch PC is loaded with redirect_pc.
  - No issue happens in the redirect cycle.
- Halt:
  - Blocks issue only.
  - An outstanding response is still pushed, and queued entries still drain to decode.
  - A redirect while halted loads the PC; fetch resumes from it when halt falls.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Outputs are driven from queue storage: no mem_data → out_instr bypass.

## Timing
- Reset values while rst_n = 0: mem_ren 0, mem_addr RESET_PC, out_valid 0, out_instr 0, out_pc 0, level 0, in-flight 0, pointers 0, fetch PC RESET_PC.
- Reset deassertion: the first issue (mem_ren = 1, mem_addr = RESET_PC) happens in the first clock cycle after rst_n rises.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and any outstanding response is lost.
- Latency, issue to out_valid:
  - issue in cycle N;
  - data present in N+1 and pushed at the edge closing N+1;
  - out_valid in N+2.
- Redirect in cycle R:
  - first issue of redirect_pc in R+1;
  - out_valid with out_pc = redirect_pc in R+3.
- Throughput: with out_ready held high, one instruction per cycle in steady state for any DEPTH ≥ 2.
- Backpressure: with out_ready low, the queue fills to exactly DEPTH entries and mem_ren goes low. Each later pop allows exactly one new issue.
- The handshake is standard valid/ready: out_instr and out_pc hold stable while out_valid && !out_ready.

## Structure
- No shared package is needed. If the CPU package exists, RESET_PC may come from it as a constant.
- One sub-module, fetch_fifo: a synchronous FIFO parametrised by WIDTH and DEPTH, with push, pop, clear, count, and head data. Its entries are 2·XLEN wide (instr, pc).
- The top level holds:
  - fetch PC and in-flight registers;
  - credit and issue logic;
  - redirect priority.

## Test plan
- Reset/startup: hold rst_n low 3 cycles with RESET_PC = 0x0010, then release, with a memory model returning addr XOR 0xA5A5.
  - Cycle 1 after release: mem_addr = 0x0010.
  - Cycle 3: out_valid with out_pc = 0x0010 and out_instr = 0xA5B5.
- Streaming: out_ready held high for 20 cycles.
  - After the first valid, out_valid stays high and out_pc increments by 1 every cycle.
- Backpressure: DEPTH = 4 with out_ready low.
  - level reaches 4 and mem_ren is 0 from then on.
  - Raising out_ready for one cycle gives exactly one new issue, and level returns to 4.
- Redirect flush: redirect with redirect_pc = 0x0200 while level = 3, one read in flight, and out_ready = 1.
  - Next cycle level = 0 and the dropped response is not pushed.
  - Next valid out_pc is 0x0200, arriving exactly 3 cycles after the redirect.
- Halt and wrap: start fetch at 0xFFFE, then raise halt once 0xFFFF has issued.
  - Queue drains 0xFFFE and 0xFFFF, with no further mem_ren.
  - Dropping halt issues 0x0000.
- Async reset mid-stream: pulse rst_n low between clock edges.
  - Outputs clear immediately.
  - Fetch restarts at RESET_PC.
  - No stale instruction appears.
